bcd_display_scan: RTL and testbench

BCD_DISPLAY_SCAN -- requirements
Module: bcd_display_scan

---
 rtl/bcd_disp_pkg.sv | 30 +++
 rtl/seg7_decode.sv | 26 ++
 rtl/bcd_display_scan.sv | 132 +++++++++++++
 tb/tb_bcd_display_scan.sv | 124 ++++++++++++
 4 files changed

// File: rtl/bcd_disp_pkg.sv
// Shared types and constants for the two-digit multiplexed BCD display scanner.
// Segment codes are active-low {g,f,e,d,c,b,a}; digit enables are active-low.
package bcd_disp_pkg;

    typedef enum logic [2:0] {
        S_OFF   = 3'd0,
        S_UNITS = 3'd1,
        S_GAP_U = 3'd2,
        S_TENS  = 3'd3,
        S_GAP_T = 3'd4
    } state_t;

    localparam logic [6:0] SEG_0    = 7'h40;
    localparam logic [6:0] SEG_1    = 7'h79;
    localparam logic [6:0] SEG_2    = 7'h24;
    localparam logic [6:0] SEG_3    = 7'h30;
    localparam logic [6:0] SEG_4    = 7'h19;
    localparam logic [6:0] SEG_5    = 7'h12;
    localparam logic [6:0] SEG_6    = 7'h02;
    localparam logic [6:0] SEG_7    = 7'h78;
    localparam logic [6:0] SEG_8    = 7'h00;
    localparam logic [6:0] SEG_9    = 7'h10;
    localparam logic [6:0] SEG_DASH = 7'h3F;
    localparam logic [6:0] SEG_OFF  = 7'h7F;

    localparam logic [1:0] AN_OFF   = 2'b11;
    localparam logic [1:0] AN_UNITS = 2'b10;
    localparam logic [1:0] AN_TENS  = 2'b01;

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD digit to active-low seven-segment code; non-BCD nibbles show a dash.
module seg7_decode
    import bcd_disp_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_display_scan.sv
// Two-digit multiplexed seven-segment scanner with guard gaps, tear-free frame
// updates via a pending register, and optional leading-zero blanking.
module bcd_display_scan
    import bcd_disp_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 50000,
    parameter int unsigned GAP_CYCLES  = 2,
    parameter int unsigned BLANK_LZ    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       load,
    input  logic [7:0] bcd_in,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       frame_done
);

    localparam int unsigned CNT_MAX = (REFRESH_DIV > GAP_CYCLES) ? REFRESH_DIV : GAP_CYCLES;
    localparam int unsigned CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] DIGIT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       pend, pend_nxt;
    logic             flag, flag_nxt;
    logic [7:0]       disp, disp_nxt;
    logic             enter_units;
    logic [3:0]       digit;
    logic [6:0]       seg_dec;
    logic [6:0]       seg_nxt;
    logic [1:0]       an_nxt;
    logic             fd_nxt;

    // State register and shared phase counter; counter restarts on every transition.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_OFF;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state || state_nxt == S_OFF)
                cnt <= '0;
            else
                cnt <= cnt + 1'b1;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        if (!en) begin
            state_nxt = S_OFF;
        end else begin
            case (state)
                S_OFF:   state_nxt = S_UNITS;
                S_UNITS: if (cnt == DIGIT_LAST) state_nxt = S_GAP_U;
                S_GAP_U: if (cnt == GAP_LAST)   state_nxt = S_TENS;
                S_TENS:  if (cnt == DIGIT_LAST) state_nxt = S_GAP_T;
                S_GAP_T: if (cnt == GAP_LAST)   state_nxt = S_UNITS;
                default: state_nxt = S_OFF;
            endcase
        end
    end

    assign enter_units = (state_nxt == S_UNITS) && (state != S_UNITS);

    // Pending/display update: display only changes at the start of a frame.
    always_comb begin
        pend_nxt = pend;
        flag_nxt = flag;
        disp_nxt = disp;
        if (enter_units) begin
            flag_nxt = 1'b0;
            if (load)
                disp_nxt = bcd_in;
            else if (flag)
                disp_nxt = pend;
        end else if (load) begin
            pend_nxt = bcd_in;
            flag_nxt = 1'b1;
        end
    end

    assign digit = (state_nxt == S_TENS) ? disp_nxt[7:4] : disp_nxt[3:0];

    seg7_decode u_dec (
        .digit (digit),
        .seg   (seg_dec)
    );

    // Output values for the upcoming state, registered below so outputs track state exactly.
    always_comb begin
        seg_nxt = SEG_OFF;
        an_nxt  = AN_OFF;
        fd_nxt  = (state == S_GAP_T) && (state_nxt == S_UNITS);
        case (state_nxt)
            S_UNITS: begin
                an_nxt  = AN_UNITS;
                seg_nxt = seg_dec;
            end
            S_TENS: begin
                if (!((BLANK_LZ != 0) && (disp_nxt[7:4] == 4'd0))) begin
                    an_nxt  = AN_TENS;
                    seg_nxt = seg_dec;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend       <= 8'h00;
            flag       <= 1'b0;
            disp       <= 8'h00;
            seg        <= SEG_OFF;
            an         <= AN_OFF;
            frame_done <= 1'b0;
        end else begin
            pend       <= pend_nxt;
            flag       <= flag_nxt;
            disp       <= disp_nxt;
            seg        <= seg_nxt;
            an         <= an_nxt;
            frame_done <= fd_nxt;
        end
    end

endmodule

// File: tb/tb_bcd_display_scan.sv
// Directed bench for bcd_display_scan with a short refresh period; expected
// segment/anode patterns are hand-computed per frame cycle.
module tb_bcd_display_scan;

    logic       clk;
    logic       rst;
    logic       en;
    logic       load;
    logic [7:0] bcd_in;
    logic [6:0] seg;
    logic [1:0] an;
    logic       frame_done;

    int n_checks;
    int n_errors;

    bcd_display_scan #(
        .REFRESH_DIV (4),
        .GAP_CYCLES  (2),
        .BLANK_LZ    (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .load       (load),
        .bcd_in     (bcd_in),
        .seg        (seg),
        .an         (an),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compares {frame_done, an, seg} against the expected 10-bit pattern.
    task automatic check(input string tag, input logic [9:0] got, input logic [9:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got fd=%b an=%b seg=%h, expected fd=%b an=%b seg=%h",
                     tag, got[9], got[8:7], got[6:0], exp[9], exp[8:7], exp[6:0]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One 12-cycle frame starting with the UNITS entry edge; optional loads are
    // raised after cycle index l1_i / l2_i so the next edge captures them.
    task automatic frame(input string name, input logic [6:0] u_seg, input logic [1:0] t_an,
                         input logic [6:0] t_seg, input logic fd0,
                         input int l1_i, input logic [7:0] l1_v,
                         input int l2_i, input logic [7:0] l2_v);
        logic [9:0] exp;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (i < 4)       exp = {(i == 0) ? fd0 : 1'b0, 2'b10, u_seg};
            else if (i < 6)  exp = {1'b0, 2'b11, 7'h7F};
            else if (i < 10) exp = {1'b0, t_an, t_seg};
            else             exp = {1'b0, 2'b11, 7'h7F};
            check($sformatf("%s_c%0d", name, i), {frame_done, an, seg}, exp);
            load = 1'b0;
            if (i == l1_i) begin load = 1'b1; bcd_in = l1_v; end
            if (i == l2_i) begin load = 1'b1; bcd_in = l2_v; end
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst    = 1'b0;
        en     = 1'b0;
        load   = 1'b0;
        bcd_in = 8'h00;
        #2 rst = 1'b1;
        tick();
        tick();
        check("reset", {frame_done, an, seg}, {1'b0, 2'b11, 7'h7F});
        rst = 1'b0;
        tick();
        check("off_idle", {frame_done, an, seg}, {1'b0, 2'b11, 7'h7F});

        // 15 loaded on the OFF->UNITS edge goes straight to the display
        en = 1'b1; load = 1'b1; bcd_in = 8'h15;
        frame("f15", 7'h12, 2'b01, 7'h79, 1'b0, 11, 8'h07, -1, 8'h00);
        // 07 coincides with the GAP_T->UNITS edge; tens blanked
        frame("f07", 7'h78, 2'b11, 7'h7F, 1'b1, -1, 8'h00, -1, 8'h00);
        // loads during TENS and GAP_T stay pending; last one wins
        frame("f07b", 7'h78, 2'b11, 7'h7F, 1'b1, 7, 8'h15, 10, 8'h09);
        frame("f09", 7'h10, 2'b11, 7'h7F, 1'b1, 11, 8'h3A, -1, 8'h00);
        frame("f3a", 7'h3F, 2'b01, 7'h30, 1'b1, -1, 8'h00, -1, 8'h00);

        // drop en mid-TENS
        for (int i = 0; i < 8; i++) tick();
        check("tens_before_drop", {frame_done, an, seg}, {1'b0, 2'b01, 7'h30});
        en = 1'b0;
        tick();
        check("en_drop", {frame_done, an, seg}, {1'b0, 2'b11, 7'h7F});
        tick();
        check("en_off_hold", {frame_done, an, seg}, {1'b0, 2'b11, 7'h7F});
        en = 1'b1;
        frame("f3a_reen", 7'h3F, 2'b01, 7'h30, 1'b0, -1, 8'h00, -1, 8'h00);

        // reset mid-UNITS with a load pending
        tick();
        check("units_fd", {frame_done, an, seg}, {1'b1, 2'b10, 7'h3F});
        load = 1'b1; bcd_in = 8'h42;
        tick();
        load = 1'b0;
        check("units_pending", {frame_done, an, seg}, {1'b0, 2'b10, 7'h3F});
        #2 rst = 1'b1;
        #1;
        check("rst_async", {frame_done, an, seg}, {1'b0, 2'b11, 7'h7F});
        tick();
        rst = 1'b0;
        frame("f_after_rst", 7'h40, 2'b11, 7'h7F, 1'b0, -1, 8'h00, -1, 8'h00);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
